// File: rtl/aes_pipe_sched.sv
// aes_pipe_sched: admission and stall scheduler for the 40-stage pipelined
// AES datapath. Tracks in-flight blocks with a per-stage valid shift
// register, freezes the whole pipe under output back-pressure, and runs the
// key reload sequence (drain, expand for KEY_CYCLES cycles, resume).
//
// Optional feature: define AES_SCHED_STALL_CNT_EN to add the 16-bit
// saturating stall_count output (cycles with pipe_en low, cleared by flush).

module aes_pipe_sched #(
    parameter int PIPE_DEPTH = 40,
    parameter int CNT_BITS   = 6,
    parameter int KEY_CYCLES = 40
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                key_load,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                pipe_en,
    output logic                key_en,
    output logic                busy,
    output logic [CNT_BITS-1:0] occupancy
`ifdef AES_SCHED_STALL_CNT_EN
    ,
    output logic [15:0]         stall_count
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_KEY_EXP,
        ST_RUN,
        ST_DRAIN
    } state_t;

    state_t                r_state;
    state_t                w_nextState;
    logic [PIPE_DEPTH-1:0] r_vld;
    logic [CNT_BITS-1:0]   r_occ;
    logic [CNT_BITS-1:0]   w_occNext;
    logic [CNT_BITS-1:0]   r_keyCnt;
    logic                  w_accept;
    logic                  w_emit;
    logic                  w_keyDone;

    // The whole pipe advances unless the tail holds a block nobody will take.
    // Holding every stage keeps bubbles in place rather than compressing them.
    assign pipe_en   = ~r_vld[PIPE_DEPTH-1] | out_ready;

    // New blocks only enter while streaming; a pending key_load closes the
    // door in the same cycle so the drain count cannot grow.
    assign in_ready  = (r_state == ST_RUN) & pipe_en & ~key_load;

    assign w_accept  = in_valid & in_ready;
    assign w_emit    = r_vld[PIPE_DEPTH-1] & out_ready;
    assign w_keyDone = (r_keyCnt == CNT_BITS'(KEY_CYCLES - 1));

    assign out_valid = r_vld[PIPE_DEPTH-1];
    assign occupancy = r_occ;
    assign key_en    = (r_state == ST_KEY_EXP);
    assign busy      = (r_state == ST_KEY_EXP) | (r_state == ST_DRAIN);

    // Occupancy after this edge; flush wins over any simultaneous accept or
    // emit, and the guards keep the count inside 0..PIPE_DEPTH.
    always_comb begin
        w_occNext = r_occ;
        if (flush) begin
            w_occNext = '0;
        end else if (w_accept && !w_emit) begin
            if (r_occ != CNT_BITS'(PIPE_DEPTH)) begin
                w_occNext = r_occ + CNT_BITS'(1);
            end
        end else if (!w_accept && w_emit) begin
            if (r_occ != '0) begin
                w_occNext = r_occ - CNT_BITS'(1);
            end
        end
    end

    // Next-state decode for the key reload sequencer. Leaving RUN or DRAIN
    // looks at the post-edge occupancy so an empty pipe goes straight to
    // expansion, and a flush in DRAIN (occupancy forced to 0) does too.
    always_comb begin
        w_nextState = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (key_load) begin
                    w_nextState = ST_KEY_EXP;
                end
            end
            ST_KEY_EXP: begin
                if (w_keyDone) begin
                    w_nextState = ST_RUN;
                end
            end
            ST_RUN: begin
                if (key_load) begin
                    if (w_occNext != '0) begin
                        w_nextState = ST_DRAIN;
                    end else begin
                        w_nextState = ST_KEY_EXP;
                    end
                end
            end
            ST_DRAIN: begin
                if (w_occNext == '0) begin
                    w_nextState = ST_KEY_EXP;
                end
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Key expansion cycle counter: counts 0..KEY_CYCLES-1 inside KEY_EXP and
    // sits at zero everywhere else so each expansion starts fresh.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_keyCnt <= '0;
        end else if (r_state == ST_KEY_EXP && !w_keyDone) begin
            r_keyCnt <= r_keyCnt + CNT_BITS'(1);
        end else begin
            r_keyCnt <= '0;
        end
    end

    // Per-stage valid tokens: shift in the accept bit when the pipe advances,
    // hold on stall, wipe on flush.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_vld <= '0;
        end else if (flush) begin
            r_vld <= '0;
        end else if (pipe_en) begin
            r_vld <= {r_vld[PIPE_DEPTH-2:0], w_accept};
        end
    end

    // Occupancy register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_occ <= '0;
        end else begin
            r_occ <= w_occNext;
        end
    end

`ifdef AES_SCHED_STALL_CNT_EN
    logic [15:0] r_stallCnt;

    assign stall_count = r_stallCnt;

    // Saturating count of cycles the datapath was frozen by back-pressure.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_stallCnt <= '0;
        end else if (flush) begin
            r_stallCnt <= '0;
        end else if (!pipe_en && r_stallCnt != 16'hFFFF) begin
            r_stallCnt <= r_stallCnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_aes_pipe_sched.sv
// Directed testbench for aes_pipe_sched: reset, key expansion, streaming,
// back-pressure, drain-before-reload, flush and reset during expansion.

module tb_aes_pipe_sched;

    localparam int PIPE_DEPTH = 40;
    localparam int CNT_BITS   = 6;
    localparam int KEY_CYCLES = 40;

    logic                clk;
    logic                n_rst;
    logic                key_load;
    logic                flush;
    logic                in_valid;
    logic                in_ready;
    logic                out_valid;
    logic                out_ready;
    logic                pipe_en;
    logic                key_en;
    logic                busy;
    logic [CNT_BITS-1:0] occupancy;
`ifdef AES_SCHED_STALL_CNT_EN
    logic [15:0]         stall_count;
`endif

    int nChecks = 0;
    int nFails  = 0;

    aes_pipe_sched #(
        .PIPE_DEPTH (PIPE_DEPTH),
        .CNT_BITS   (CNT_BITS),
        .KEY_CYCLES (KEY_CYCLES)
    ) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .key_load   (key_load),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .pipe_en    (pipe_en),
        .key_en     (key_en),
        .busy       (busy),
        .occupancy  (occupancy)
`ifdef AES_SCHED_STALL_CNT_EN
        ,
        .stall_count(stall_count)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive all inputs just after a falling edge and let combinational outputs settle.
    task automatic applyStimulus(input logic kl, input logic fl, input logic iv, input logic ordy);
        key_load  = kl;
        flush     = fl;
        in_valid  = iv;
        out_ready = ordy;
        #1;
    endtask

    task automatic nextCycle;
        @(negedge clk);
    endtask

    task automatic test_reset;
        n_rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        nextCycle();
        nChecks++; if (in_ready !== 1'b0) begin nFails++; $display("[TB] FAIL reset_in_ready: got %b expected 0", in_ready); end
        nChecks++; if (out_valid !== 1'b0) begin nFails++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
        nChecks++; if (key_en !== 1'b0) begin nFails++; $display("[TB] FAIL reset_key_en: got %b expected 0", key_en); end
        nChecks++; if (busy !== 1'b0) begin nFails++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        nChecks++; if (occupancy !== 6'd0) begin nFails++; $display("[TB] FAIL reset_occupancy: got %0d expected 0", occupancy); end
        nChecks++; if (pipe_en !== 1'b1) begin nFails++; $display("[TB] FAIL reset_pipe_en: got %b expected 1", pipe_en); end
        n_rst = 1'b1;
        nextCycle();
        // Still IDLE: no key yet, so nothing may be admitted.
        nChecks++; if (in_ready !== 1'b0) begin nFails++; $display("[TB] FAIL idle_in_ready: got %b expected 0", in_ready); end
    endtask

    task automatic test_key_expansion;
        int cnt;
        int busyBad;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        cnt = 0;
        busyBad = 0;
        while (key_en === 1'b1 && cnt < 100) begin
            if (busy !== 1'b1) busyBad++;
            cnt++;
            nextCycle();
        end
        nChecks++; if (cnt !== KEY_CYCLES) begin nFails++; $display("[TB] FAIL keyexp_len: got %0d cycles expected %0d", cnt, KEY_CYCLES); end
        nChecks++; if (busyBad !== 0) begin nFails++; $display("[TB] FAIL keyexp_busy: got %0d low cycles expected 0", busyBad); end
        nChecks++; if (busy !== 1'b0) begin nFails++; $display("[TB] FAIL keyexp_busy_after: got %b expected 0", busy); end
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        nChecks++; if (in_ready !== 1'b1) begin nFails++; $display("[TB] FAIL keyexp_in_ready: got %b expected 1", in_ready); end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_stream;
        int edges;
        int peak;
        int run;
        peak = 0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
            nChecks++; if (in_ready !== 1'b1) begin nFails++; $display("[TB] FAIL stream_in_ready: got %b expected 1", in_ready); end
            nextCycle();
            if (int'(occupancy) > peak) peak = int'(occupancy);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        edges = 5;
        while (out_valid !== 1'b1 && edges < 100) begin
            nextCycle();
            edges++;
            if (int'(occupancy) > peak) peak = int'(occupancy);
        end
        nChecks++; if (peak !== 5) begin nFails++; $display("[TB] FAIL stream_peak: got %0d expected 5", peak); end
        nChecks++; if (edges !== PIPE_DEPTH) begin nFails++; $display("[TB] FAIL stream_latency: got %0d edges expected %0d", edges, PIPE_DEPTH); end
        run = 0;
        while (out_valid === 1'b1 && run < 100) begin
            run++;
            nextCycle();
        end
        nChecks++; if (run !== 5) begin nFails++; $display("[TB] FAIL stream_out_run: got %0d expected 5", run); end
        nChecks++; if (occupancy !== 6'd0) begin nFails++; $display("[TB] FAIL stream_occ_end: got %0d expected 0", occupancy); end
    endtask

    task automatic test_backpressure;
        int acc;
        int n;
        acc = 0;
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        while (in_ready === 1'b1 && acc < 100) begin
            acc++;
            nextCycle();
        end
        nChecks++; if (acc !== PIPE_DEPTH) begin nFails++; $display("[TB] FAIL bp_accepts: got %0d expected %0d", acc, PIPE_DEPTH); end
        for (int i = 0; i < 5; i++) nextCycle();
        nChecks++; if (occupancy !== 6'd40) begin nFails++; $display("[TB] FAIL bp_occ_held: got %0d expected 40", occupancy); end
        nChecks++; if (pipe_en !== 1'b0) begin nFails++; $display("[TB] FAIL bp_pipe_en: got %b expected 0", pipe_en); end
        nChecks++; if (in_ready !== 1'b0) begin nFails++; $display("[TB] FAIL bp_in_ready: got %b expected 0", in_ready); end
        nChecks++; if (out_valid !== 1'b1) begin nFails++; $display("[TB] FAIL bp_out_valid: got %b expected 1", out_valid); end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        n = 0;
        while (out_valid === 1'b1 && n < 100) begin
            nChecks++; if (int'(occupancy) !== PIPE_DEPTH - n) begin nFails++; $display("[TB] FAIL bp_drain_occ: got %0d expected %0d", occupancy, PIPE_DEPTH - n); end
            n++;
            nextCycle();
        end
        nChecks++; if (n !== PIPE_DEPTH) begin nFails++; $display("[TB] FAIL bp_out_run: got %0d expected %0d", n, PIPE_DEPTH); end
        nChecks++; if (occupancy !== 6'd0) begin nFails++; $display("[TB] FAIL bp_occ_end: got %0d expected 0", occupancy); end
    endtask

    task automatic test_reload_drain;
        int emitted;
        int readySeen;
        int guard;
        int cnt;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
            nextCycle();
        end
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
        nChecks++; if (in_ready !== 1'b0) begin nFails++; $display("[TB] FAIL drain_keyload_mask: got %b expected 0", in_ready); end
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        nChecks++; if (busy !== 1'b1) begin nFails++; $display("[TB] FAIL drain_busy: got %b expected 1", busy); end
        nChecks++; if (key_en !== 1'b0) begin nFails++; $display("[TB] FAIL drain_key_en: got %b expected 0", key_en); end
        emitted = 0;
        readySeen = 0;
        guard = 0;
        while (key_en !== 1'b1 && guard < 100) begin
            if (out_valid === 1'b1) emitted++;
            if (in_ready === 1'b1) readySeen++;
            guard++;
            nextCycle();
        end
        nChecks++; if (emitted !== 3) begin nFails++; $display("[TB] FAIL drain_emitted: got %0d expected 3", emitted); end
        nChecks++; if (readySeen !== 0) begin nFails++; $display("[TB] FAIL drain_in_ready: got %0d ready cycles expected 0", readySeen); end
        nChecks++; if (occupancy !== 6'd0) begin nFails++; $display("[TB] FAIL drain_occ: got %0d expected 0", occupancy); end
        cnt = 0;
        while (key_en === 1'b1 && cnt < 100) begin
            if (in_ready === 1'b1) readySeen++;
            cnt++;
            nextCycle();
        end
        nChecks++; if (cnt !== KEY_CYCLES) begin nFails++; $display("[TB] FAIL drain_keyexp_len: got %0d expected %0d", cnt, KEY_CYCLES); end
        nChecks++; if (in_ready !== 1'b1) begin nFails++; $display("[TB] FAIL drain_resume: got %b expected 1", in_ready); end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_flush;
        int outs;
        int cnt;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
            nextCycle();
        end
        nChecks++; if (occupancy !== 6'd10) begin nFails++; $display("[TB] FAIL flush_occ_before: got %0d expected 10", occupancy); end
        // Flush coincides with a would-be accept; the flush must win.
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        nChecks++; if (occupancy !== 6'd0) begin nFails++; $display("[TB] FAIL flush_occ: got %0d expected 0", occupancy); end
        nChecks++; if (out_valid !== 1'b0) begin nFails++; $display("[TB] FAIL flush_out_valid: got %b expected 0", out_valid); end
        nChecks++; if (in_ready !== 1'b1) begin nFails++; $display("[TB] FAIL flush_state_run: got %b expected 1", in_ready); end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        outs = 0;
        for (int i = 0; i < PIPE_DEPTH + 5; i++) begin
            if (out_valid === 1'b1) outs++;
            nextCycle();
        end
        nChecks++; if (outs !== 0) begin nFails++; $display("[TB] FAIL flush_ghost_out: got %0d expected 0", outs); end

        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
            nextCycle();
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        nextCycle();
        nChecks++; if (busy !== 1'b1 || key_en !== 1'b0) begin nFails++; $display("[TB] FAIL flush_drain_entry: got busy=%b key_en=%b expected busy=1 key_en=0", busy, key_en); end
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        nChecks++; if (key_en !== 1'b1) begin nFails++; $display("[TB] FAIL flush_drain_keyexp: got %b expected 1", key_en); end
        nChecks++; if (occupancy !== 6'd0) begin nFails++; $display("[TB] FAIL flush_drain_occ: got %0d expected 0", occupancy); end
        cnt = 0;
        while (key_en === 1'b1 && cnt < 100) begin
            cnt++;
            nextCycle();
        end
        nChecks++; if (cnt !== KEY_CYCLES) begin nFails++; $display("[TB] FAIL flush_keyexp_len: got %0d expected %0d", cnt, KEY_CYCLES); end
    endtask

    task automatic test_reset_mid_key;
        int cnt;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        nChecks++; if (key_en !== 1'b1) begin nFails++; $display("[TB] FAIL empty_reload_key_en: got %b expected 1", key_en); end
        for (int i = 0; i < 20; i++) nextCycle();
        nChecks++; if (key_en !== 1'b1) begin nFails++; $display("[TB] FAIL midkey_key_en: got %b expected 1", key_en); end
        n_rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        nChecks++; if (key_en !== 1'b0 || busy !== 1'b0) begin nFails++; $display("[TB] FAIL midkey_rst_key: got key_en=%b busy=%b expected 0 0", key_en, busy); end
        nChecks++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin nFails++; $display("[TB] FAIL midkey_rst_hs: got in_ready=%b out_valid=%b expected 0 0", in_ready, out_valid); end
        nChecks++; if (occupancy !== 6'd0 || pipe_en !== 1'b1) begin nFails++; $display("[TB] FAIL midkey_rst_occ: got occ=%0d pipe_en=%b expected 0 1", occupancy, pipe_en); end
        nextCycle();
        n_rst = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        cnt = 0;
        while (key_en === 1'b1 && cnt < 100) begin
            cnt++;
            nextCycle();
        end
        nChecks++; if (cnt !== KEY_CYCLES) begin nFails++; $display("[TB] FAIL midkey_restart_len: got %0d expected %0d", cnt, KEY_CYCLES); end
    endtask

    initial begin
        n_rst     = 1'b0;
        key_load  = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_key_expansion();
        test_stream();
        test_backpressure();
        test_reload_drain();
        test_flush();
        test_reset_mid_key();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/aes_pipe_sched.md
# aes_pipe_sched

Scheduler for the 40-stage pipelined AES datapath. Admits plaintext blocks through a valid/ready handshake and tracks in-flight tokens with a per-stage valid shift register. Stalls the whole pipeline when the output consumer back-pressures. Sequences key reloads: drain the pipeline, run key expansion for a fixed cycle count, then resume streaming.

## Interface
Parameters:
- PIPE_DEPTH, 40, number of datapath stages; latency of an unstalled block
- CNT_BITS, 6, width of occupancy and key counter; must hold PIPE_DEPTH and KEY_CYCLES
- KEY_CYCLES, 40, cycles key_en is held high per key expansion

Ports:
- clk  in  1  system clock, rising edge
- n_rst  in  1  asynchronous active-low reset
- key_load  in  1  request new key expansion (level, sampled each cycle)
- flush  in  1  synchronous clear of all in-flight tokens
- in_valid  in  1  upstream block available
- in_ready  out  1  scheduler accepts block this cycle
- out_valid  out  1  block at final stage is valid
- out_ready  in  1  downstream accepts output block
- pipe_en  out  1  advance all datapath stages this cycle
- key_en  out  1  enable key expansion engine
- busy  out  1  high in KEY_EXP or DRAIN
- occupancy  out  CNT_BITS  number of valid tokens in the pipeline

## Operation
- States: IDLE (no key loaded), KEY_EXP, RUN, DRAIN.
- IDLE: key_load=1 -> KEY_EXP. Otherwise stay. in_ready=0.
- KEY_EXP: key_en=1. Key counter runs 0..KEY_CYCLES-1. After the cycle with count KEY_CYCLES-1 -> RUN. key_load is ignored.
- RUN:
  - in_ready = pipe_en & ~key_load.
  - key_load=1 -> DRAIN if occupancy != 0 (after this edge's update), else KEY_EXP.
- DRAIN:
  - in_ready=0; pipeline keeps emitting.
  - When occupancy reaches 0 -> KEY_EXP.
  - key_load is ignored (reload already pending).
- Valid shift register vld[PIPE_DEPTH-1:0]:
  - On pipe_en=1: vld[0] <= accept (in_valid & in_ready), and vld[i] <= vld[i-1].
  - On pipe_en=0: hold.
- pipe_en = ~vld[PIPE_DEPTH-1] | out_ready (combinational). Bubbles upstream of a stalled tail are not compressed.
- out_valid = vld[PIPE_DEPTH-1].
- occupancy:
  - +1 on accept, -1 on out_valid & out_ready; both together leaves it unchanged.
  - Never exceeds PIPE_DEPTH and never underflows.
- flush=1: vld and occupancy cleared at the next edge; state is unchanged, except DRAIN -> KEY_EXP. flush has priority over accept and shift that cycle.
- Reset (async, any state): state IDLE, vld=0, occupancy=0, key counter 0.

## Timing
- Reset values: in_ready 0, out_valid 0, key_en 0, busy 0, occupancy 0, pipe_en 1.
- Block accepted in cycle t (edge t) produces out_valid in cycle t+PIPE_DEPTH-1 with no stalls (PIPE_DEPTH edges from accept edge to tail register, counting the accept edge). Each stalled cycle adds 1.
- Back-to-back accepts give one block per cycle throughput.
- key_en is high for exactly KEY_CYCLES consecutive cycles. in_ready can rise the first cycle after key_en falls.
- Reload from RUN with an empty pipeline: key_en rises the cycle after key_load is sampled.
- All handshakes complete on the edge where both valid and ready are high. Outputs other than pipe_en and in_ready are registered or decoded from registered state only.

## Configuration
- AES_SCHED_STALL_CNT_EN defined: adds output port stall_count (16 bits).
  - Increments each cycle pipe_en=0; saturates at 16'hFFFF.
  - Cleared by reset and by flush.
- Not defined: port and counter absent; no other behaviour changes.

## Test plan
- Reset, key_load pulse in IDLE -> key_en high exactly 40 cycles, busy high for those cycles, then in_ready=1 with in_valid=1.
- Stream 5 blocks back-to-back with out_ready=1 -> occupancy peaks at 5; out_valid high for 5 consecutive cycles starting 40 cycles after the first accept; occupancy returns to 0.
- Fill 40 blocks, hold out_ready=0 -> pipe_en=0, in_ready=0, occupancy=40 held. Release out_ready -> one block per cycle, no loss or duplication (check the vld sequence).
- key_load in RUN with 3 blocks in flight -> DRAIN, in_ready=0 until all 3 emitted, then 40 cycles key_en, then RUN.
- flush with 10 in flight -> occupancy 0 and out_valid 0 next cycle. Flush during DRAIN -> KEY_EXP next cycle.
- Assert n_rst low mid-KEY_EXP at count 20 -> immediately IDLE with all outputs at reset values. A new key_load restarts the count from 0.
